// File: rtl/ef_gpio8_apb.sv
// ef_gpio8_apb: 8-bit GPIO with APB registers and a 32-source pin interrupt controller
module ef_gpio8_apb (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic [7:0]  io_in,
  output logic [7:0]  io_out,
  output logic [7:0]  io_oe,
  output logic        irq
);
  logic [7:0]  sync1_q, sync1_d, datai_q, datai_d, prev_q, prev_d;
  logic [7:0]  datao_q, datao_d, dir_q, dir_d;
  logic [31:0] im_q, im_d, ris_q, ris_d;
  logic [15:0] a;
  logic        wr;
  logic [31:0] ev, ic;
  logic        unused_addr;
  assign a = PADDR[15:0];
  assign unused_addr = ^PADDR[31:16];
  assign wr = PSEL & PENABLE & PWRITE;
  // event groups: high level, low level, rising edge, falling edge
  assign ev = {~datai_q & prev_q, datai_q & ~prev_q, ~datai_q, datai_q};
  assign ic = (wr && a == 16'hFF0C) ? PWDATA : 32'h0;
  always_comb begin
    sync1_d = io_in;
    datai_d = sync1_q;
    prev_d  = datai_q;
    datao_d = (wr && a == 16'h0004) ? PWDATA[7:0] : datao_q;
    dir_d   = (wr && a == 16'h0008) ? PWDATA[7:0] : dir_q;
    im_d    = (wr && a == 16'hFF00) ? PWDATA : im_q;
    ris_d   = (ris_q & ~ic) | ev;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync1_q <= '0;
      datai_q <= '0;
      prev_q  <= '0;
      datao_q <= '0;
      dir_q   <= '0;
      im_q    <= '0;
      ris_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      datai_q <= datai_d;
      prev_q  <= prev_d;
      datao_q <= datao_d;
      dir_q   <= dir_d;
      im_q    <= im_d;
      ris_q   <= ris_d;
    end
  end
  assign PRDATA = (a == 16'h0000) ? {24'h0, datai_q} :
                  (a == 16'h0004) ? {24'h0, datao_q} :
                  (a == 16'h0008) ? {24'h0, dir_q}   :
                  (a == 16'hFF00) ? im_q             :
                  (a == 16'hFF04) ? (ris_q & im_q)   :
                  (a == 16'hFF08) ? ris_q            : 32'h0;
  assign PREADY = 1'b1;
  assign io_out = datao_q;
  assign io_oe  = dir_q;
  assign irq    = |(ris_q & im_q);
endmodule

// File: tb/tb_ef_gpio8_apb.sv
// tb_ef_gpio8_apb: directed-vector self-checking bench for ef_gpio8_apb
module tb_ef_gpio8_apb;
  logic        clk = 1'b0, rst;
  logic [31:0] paddr, pwdata, prdata, rd;
  logic        pwrite, psel, penable, pready, irq;
  logic [7:0]  io_in, io_out, io_oe;
  int          checks = 0, errors = 0;
  ef_gpio8_apb dut (
    .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PWRITE(pwrite), .PSEL(psel),
    .PENABLE(penable), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
    .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic apb_write(input logic [31:0] ad, input logic [31:0] d);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = ad; pwdata = d;
    @(negedge clk);
    penable = 1;
    @(posedge clk);
    #1 psel = 0; penable = 0; pwrite = 0;
  endtask
  task automatic apb_read(input logic [31:0] ad, output logic [31:0] d);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 0; paddr = ad;
    @(negedge clk);
    penable = 1;
    #1 d = prdata;
    @(posedge clk);
    #1 psel = 0; penable = 0;
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; paddr = 0; pwdata = 0; pwrite = 0; psel = 0; penable = 0; io_in = 8'h00;
    cycles(3);
    chk("rst_io_out", {24'h0, io_out}, 32'h0);
    chk("rst_io_oe", {24'h0, io_oe}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_pready", {31'h0, pready}, 32'h1);
    foreach (dut.PRDATA[i]) if (i < 7) begin
      logic [31:0] offs [7];
      offs = '{32'h0000, 32'h0004, 32'h0008, 32'hFF00, 32'hFF04, 32'hFF08, 32'hFF0C};
      apb_read(offs[i], rd);
      chk($sformatf("rst_reg_%h", offs[i]), rd, 32'h0);
    end
    @(negedge clk) rst = 0;
    cycles(1);
    apb_read(32'hFF08, rd);
    chk("ris_low_after_rst", rd, 32'h0000FF00);
    apb_write(32'hFF0C, 32'hFFFFFFFF);
    apb_read(32'hFF08, rd);
    chk("ris_low_persists", rd, 32'h0000FF00);
    apb_write(32'h0008, 32'hFF);
    chk("io_oe_ff", {24'h0, io_oe}, 32'hFF);
    apb_write(32'h0004, 32'hA5);
    chk("io_out_a5", {24'h0, io_out}, 32'hA5);
    apb_read(32'h0004, rd);
    chk("datao_rd", rd, 32'hA5);
    apb_write(32'h0004, 32'hFFFFFF3C);
    apb_read(32'h12340004, rd);
    chk("datao_upper_ign", rd, 32'h3C);
    apb_write(32'h0004, 32'hA5);
    apb_write(32'h0008, 32'h00);
    chk("io_oe_00", {24'h0, io_oe}, 32'h0);
    io_in = 8'hAB;
    cycles(3);
    apb_read(32'h0000, rd);
    chk("datai_ab", rd, 32'hAB);
    io_in = 8'hAA;
    cycles(4);
    apb_write(32'hFF0C, 32'hFFFFFFFF);
    apb_read(32'hFF08, rd);
    chk("ris_levels_aa", rd, 32'h000055AA);
    apb_write(32'hFF00, 32'h00010000);
    chk("irq_idle", {31'h0, irq}, 32'h0);
    paddr = 32'h0000;
    @(negedge clk) io_in = 8'hAB;
    cycles(2);
    chk("datai_2edges", prdata, 32'hAB);
    chk("irq_not_yet", {31'h0, irq}, 32'h0);
    cycles(1);
    chk("irq_rise", {31'h0, irq}, 32'h1);
    apb_read(32'hFF08, rd);
    chk("ris_rise", rd, 32'h000155AB);
    apb_read(32'hFF04, rd);
    chk("mis_rise", rd, 32'h00010000);
    apb_write(32'hFF0C, 32'h00010000);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    apb_read(32'hFF08, rd);
    chk("ris_after_ic", rd, 32'h000055AB);
    apb_write(32'hFF00, 32'h00000001);
    chk("irq_level", {31'h0, irq}, 32'h1);
    apb_write(32'hFF0C, 32'h00000001);
    chk("irq_level_kept", {31'h0, irq}, 32'h1);
    apb_read(32'hFF08, rd);
    chk("ris0_kept", rd & 32'h1, 32'h1);
    io_in = 8'hAA;
    cycles(3);
    apb_read(32'hFF08, rd);
    chk("ris_fall", rd, 32'h010055AB);
    apb_read(32'h0100, rd);
    chk("unmapped_rd", rd, 32'h0);
    apb_write(32'h0100, 32'hFFFFFFFF);
    apb_write(32'hFF04, 32'hFFFFFFFF);
    apb_write(32'h0000, 32'hFFFFFFFF);
    apb_read(32'h0004, rd);
    chk("datao_unchanged", rd, 32'hA5);
    apb_read(32'h0008, rd);
    chk("dir_unchanged", rd, 32'h0);
    apb_read(32'hFF00, rd);
    chk("im_unchanged", rd, 32'h1);
    apb_read(32'hFF0C, rd);
    chk("ic_reads_0", rd, 32'h0);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0004; pwdata = 32'h77;
    @(negedge clk);
    penable = 1; rst = 1;
    @(posedge clk);
    #1 psel = 0; penable = 0; pwrite = 0;
    chk("midrst_io_out", {24'h0, io_out}, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk) rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
